// File: rtl/reset_req_gen_pkg.sv
// Shared definitions for the reset request generator: FSM state encoding
// and the codes reported on rst_cause.
package reset_req_gen_pkg;

    // Sequencer states. ASSERT is the reset value so that power-on runs
    // through the same minimum-width pulse as every other request.
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ASSERT   = 2'd1,
        WAIT_FB  = 2'd2,
        COOLDOWN = 2'd3
    } state_t;

    // Cause of the most recent reset sequence (2'b11 is reserved).
    localparam logic [1:0] CAUSE_POR  = 2'b00;
    localparam logic [1:0] CAUSE_EXT  = 2'b01;
    localparam logic [1:0] CAUSE_SOFT = 2'b10;

endpackage

// File: rtl/reset_req_gen_debounce.sv
// External reset pin conditioning: two-flop synchroniser followed by a
// consecutive-low counter. ext_req rises once DEBOUNCE_CYCLES synchronised
// lows have been seen in a row and falls on the first synchronised high.
module rst_pin_debounce #(
    parameter int DEBOUNCE_CYCLES = 8,
    parameter int CNT_W           = 8
) (
    input  logic sys_clk,
    input  logic async_rstn_in,
    input  logic ext_rstn_raw,
    output logic ext_req
);

    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync_reg;
    logic [CNT_W-1:0] deb_cnt_reg;
    logic             ext_req_reg;

    // Synchroniser chain; preset high so a reset never looks like a pin press.
    always_ff @(posedge sys_clk or negedge async_rstn_in) begin
        if (!async_rstn_in) begin
            sync_reg <= 2'b11;
        end else begin
            sync_reg <= {sync_reg[0], ext_rstn_raw};
        end
    end

    // Count consecutive synchronised lows (saturating); any high restarts it.
    always_ff @(posedge sys_clk or negedge async_rstn_in) begin
        if (!async_rstn_in) begin
            deb_cnt_reg <= '0;
            ext_req_reg <= 1'b0;
        end else if (sync_reg[1]) begin
            deb_cnt_reg <= '0;
            ext_req_reg <= 1'b0;
        end else begin
            deb_cnt_reg <= (&deb_cnt_reg) ? deb_cnt_reg : deb_cnt_reg + 1'b1;
            // Previous run already holds DEBOUNCE_CYCLES-1 lows plus this one.
            ext_req_reg <= (deb_cnt_reg >= DEB_LAST);
        end
    end

    assign ext_req = ext_req_reg;

endmodule

// File: rtl/reset_req_gen.sv
// Producer of the global reset request. Arbitrates power-on, debounced
// external pin and soft requests, drives a minimum-width registered
// gen_rstn, then watches the synchroniser feedback to confirm release.
module reset_req_gen
    import reset_req_gen_pkg::*;
#(
    parameter int PULSE_CYCLES    = 16,
    parameter int DEBOUNCE_CYCLES = 8,
    parameter int COOLDOWN_CYCLES = 4,
    parameter int FB_TIMEOUT      = 32,
    parameter int CNT_W           = 8
) (
    input  logic       sys_clk,
    input  logic       async_rstn_in,
    input  logic       ext_rstn_raw,
    input  logic       soft_rst_req,
    input  logic       sync_rstn_fb,
    output logic       gen_rstn,
    output logic       rst_busy,
    output logic       rst_done,
    output logic [1:0] rst_cause,
    output logic       rst_err
);

    // Terminal counts: the counter is cleared on entry, so the last cycle
    // of an N-cycle phase sees N-1.
    localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] COOL_LAST  = CNT_W'(COOLDOWN_CYCLES - 1);
    localparam logic [CNT_W-1:0] FB_LAST    = CNT_W'(FB_TIMEOUT - 1);

    logic ext_req;

    state_t           state_reg,    state_next;
    logic [CNT_W-1:0] cnt_reg,      cnt_next;
    logic [1:0]       cause_reg,    cause_next;
    logic             pending_reg,  pending_next;
    logic             done_reg,     done_next;
    logic             err_reg,      err_next;
    logic             gen_rstn_reg, gen_rstn_next;

    rst_pin_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_debounce (
        .sys_clk       (sys_clk),
        .async_rstn_in (async_rstn_in),
        .ext_rstn_raw  (ext_rstn_raw),
        .ext_req       (ext_req)
    );

    // State, counter and all outputs are registered; reset starts a POR pulse.
    always_ff @(posedge sys_clk or negedge async_rstn_in) begin
        if (!async_rstn_in) begin
            state_reg    <= ASSERT;
            cnt_reg      <= '0;
            cause_reg    <= CAUSE_POR;
            pending_reg  <= 1'b0;
            done_reg     <= 1'b0;
            err_reg      <= 1'b0;
            gen_rstn_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            cause_reg    <= cause_next;
            pending_reg  <= pending_next;
            done_reg     <= done_next;
            err_reg      <= err_next;
            gen_rstn_reg <= gen_rstn_next;
        end
    end

    // Next-state decode: request arbitration, pulse timing and feedback watch.
    always_comb begin
        state_next   = state_reg;
        cnt_next     = (&cnt_reg) ? cnt_reg : cnt_reg + 1'b1;
        cause_next   = cause_reg;
        pending_next = pending_reg;
        done_next    = 1'b0;
        err_next     = err_reg;

        case (state_reg)
            IDLE: begin
                // External wins a tie; the coincident soft request is dropped.
                if (ext_req) begin
                    state_next   = ASSERT;
                    cause_next   = CAUSE_EXT;
                    pending_next = 1'b0;
                end else if (soft_rst_req || pending_reg) begin
                    state_next   = ASSERT;
                    cause_next   = CAUSE_SOFT;
                    pending_next = 1'b0;
                end
            end
            ASSERT: begin
                // A held external pin stretches the pulse past its minimum.
                if ((cnt_reg >= PULSE_LAST) && !ext_req) begin
                    state_next = WAIT_FB;
                end
            end
            WAIT_FB: begin
                if (ext_req) begin
                    state_next = ASSERT;
                    cause_next = CAUSE_EXT;
                end else if (sync_rstn_fb) begin
                    state_next = COOLDOWN;
                    done_next  = 1'b1;
                end else if (cnt_reg >= FB_LAST) begin
                    state_next = COOLDOWN;
                    err_next   = 1'b1;
                end
            end
            COOLDOWN: begin
                // Soft pulses are single-cycle, so remember them for IDLE.
                if (soft_rst_req) begin
                    pending_next = 1'b1;
                end
                if (cnt_reg >= COOL_LAST) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        if (state_next != state_reg) begin
            cnt_next = '0;
        end

        gen_rstn_next = (state_next != ASSERT);
    end

    assign gen_rstn  = gen_rstn_reg;
    assign rst_busy  = (state_reg != IDLE);
    assign rst_done  = done_reg;
    assign rst_cause = cause_reg;
    assign rst_err   = err_reg;

endmodule

// File: tb/tb_reset_req_gen.sv
// Self-checking bench for reset_req_gen: directed scenarios followed by
// random traffic, every cycle compared against a phase/time reference model.
module tb_reset_req_gen;

    localparam int PULSE = 16;
    localparam int DEB   = 8;
    localparam int COOL  = 4;
    localparam int FBTO  = 32;

    // Reference-model phases.
    localparam int PH_IDLE  = 0;
    localparam int PH_LOW   = 1;
    localparam int PH_AWAIT = 2;
    localparam int PH_COOL  = 3;

    logic       sys_clk = 1'b0;
    logic       async_rstn_in;
    logic       ext_rstn_raw;
    logic       soft_rst_req;
    logic       sync_rstn_fb;
    logic       gen_rstn;
    logic       rst_busy;
    logic       rst_done;
    logic [1:0] rst_cause;
    logic       rst_err;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model state.
    int m_phase, m_age, m_cause;
    int run0, run1, run2;
    bit m_pending, m_done, m_err, m_ext;

    reset_req_gen #(
        .PULSE_CYCLES    (PULSE),
        .DEBOUNCE_CYCLES (DEB),
        .COOLDOWN_CYCLES (COOL),
        .FB_TIMEOUT      (FBTO),
        .CNT_W           (8)
    ) dut (
        .sys_clk       (sys_clk),
        .async_rstn_in (async_rstn_in),
        .ext_rstn_raw  (ext_rstn_raw),
        .soft_rst_req  (soft_rst_req),
        .sync_rstn_fb  (sync_rstn_fb),
        .gen_rstn      (gen_rstn),
        .rst_busy      (rst_busy),
        .rst_done      (rst_done),
        .rst_cause     (rst_cause),
        .rst_err       (rst_err)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", tag, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        m_phase   = PH_LOW;
        m_age     = 0;
        m_cause   = 0;
        m_pending = 0;
        m_done    = 0;
        m_err     = 0;
        m_ext     = 0;
        run0      = 0;
        run1      = 0;
        run2      = 0;
    endtask

    // One clock edge of the reference: phase rules, then the pin filter.
    // m_ext is the debounced request as it stood before this edge.
    task automatic model_step();
        int nxt;
        int new_run;
        if (!async_rstn_in) begin
            model_reset();
            return;
        end
        nxt    = m_phase;
        m_done = 0;
        case (m_phase)
            PH_IDLE: begin
                if (m_ext) begin
                    nxt = PH_LOW; m_cause = 1; m_pending = 0;
                end else if (soft_rst_req || m_pending) begin
                    nxt = PH_LOW; m_cause = 2; m_pending = 0;
                end
            end
            PH_LOW: begin
                if (m_age + 1 >= PULSE && !m_ext) nxt = PH_AWAIT;
            end
            PH_AWAIT: begin
                if (m_ext) begin
                    nxt = PH_LOW; m_cause = 1;
                end else if (sync_rstn_fb) begin
                    nxt = PH_COOL; m_done = 1;
                end else if (m_age + 1 >= FBTO) begin
                    nxt = PH_COOL; m_err = 1;
                end
            end
            default: begin
                if (soft_rst_req) m_pending = 1;
                if (m_age + 1 >= COOL) nxt = PH_IDLE;
            end
        endcase
        m_age   = (nxt != m_phase) ? 0 : m_age + 1;
        m_phase = nxt;
        // Pin request: DEB consecutive lows, seen through two sync stages.
        new_run = ext_rstn_raw ? 0 : run0 + 1;
        run2    = run1;
        run1    = run0;
        run0    = new_run;
        m_ext   = (run2 >= DEB);
    endtask

    task automatic compare_all();
        check("gen_rstn",  int'(gen_rstn),  (m_phase != PH_LOW) ? 1 : 0);
        check("rst_busy",  int'(rst_busy),  (m_phase != PH_IDLE) ? 1 : 0);
        check("rst_done",  int'(rst_done),  int'(m_done));
        check("rst_cause", int'(rst_cause), m_cause);
        check("rst_err",   int'(rst_err),   int'(m_err));
    endtask

    // Inputs are set at the falling edge; the model and DUT see the same
    // values at the rising edge, and outputs are compared at the next fall.
    task automatic step_cycle();
        @(posedge sys_clk);
        model_step();
        @(negedge sys_clk);
        cyc++;
        compare_all();
    endtask

    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) step_cycle();
    endtask

    task automatic soft_pulse();
        soft_rst_req = 1'b1;
        step_cycle();
        soft_rst_req = 1'b0;
    endtask

    task automatic async_hit(input int hold);
        async_rstn_in = 1'b0;
        model_reset();
        #1;
        compare_all();
        check("async_gen_low", int'(gen_rstn), 0);
        run_cycles(hold);
        async_rstn_in = 1'b1;
    endtask

    initial begin
        int low_cnt;
        int fb_low_left;
        int burst_left;

        async_rstn_in = 1'b0;
        ext_rstn_raw  = 1'b1;
        soft_rst_req  = 1'b0;
        sync_rstn_fb  = 1'b1;
        model_reset();

        // Power-on reset values, then release with feedback tied high.
        run_cycles(2);
        check("por_cause", int'(rst_cause), 0);
        async_rstn_in = 1'b1;
        run_cycles(30);
        $display("POR sequence: cause=%0d err=%0d busy=%0d", rst_cause, rst_err, rst_busy);

        // Soft request from IDLE: exactly PULSE cycles low.
        soft_pulse();
        low_cnt = (gen_rstn == 1'b0) ? 1 : 0;
        for (int i = 0; i < 40; i++) begin
            step_cycle();
            if (gen_rstn == 1'b0) low_cnt++;
        end
        check("soft_low_width", low_cnt, PULSE);
        check("soft_cause", int'(rst_cause), 2);
        $display("soft sequence: low=%0d cause=%0d", low_cnt, rst_cause);

        // Short glitch on the external pin is ignored.
        ext_rstn_raw = 1'b0;
        run_cycles(5);
        ext_rstn_raw = 1'b1;
        run_cycles(20);
        check("glitch_no_busy", int'(rst_busy), 0);
        $display("external glitch: busy=%0d", rst_busy);

        // Long external press stretches the pulse.
        ext_rstn_raw = 1'b0;
        low_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            step_cycle();
            if (gen_rstn == 1'b0) low_cnt++;
        end
        ext_rstn_raw = 1'b1;
        for (int i = 0; i < 50; i++) begin
            step_cycle();
            if (gen_rstn == 1'b0) low_cnt++;
        end
        check("ext_low_width", low_cnt, 40 - DEB + 1);
        check("ext_cause", int'(rst_cause), 1);
        $display("external press: low=%0d cause=%0d", low_cnt, rst_cause);

        // External and soft in the same IDLE cycle: external wins.
        ext_rstn_raw = 1'b0;
        for (int i = 0; i < 20 && !m_ext; i++) step_cycle();
        soft_pulse();
        ext_rstn_raw = 1'b1;
        run_cycles(60);
        check("tie_cause", int'(rst_cause), 1);
        $display("simultaneous requests: cause=%0d busy=%0d", rst_cause, rst_busy);

        // Soft request during cooldown is queued for IDLE.
        soft_pulse();
        for (int i = 0; i < 100 && m_phase != PH_COOL; i++) step_cycle();
        soft_pulse();
        run_cycles(6);
        check("queued_busy", int'(rst_busy), 1);
        run_cycles(50);
        check("queued_cause", int'(rst_cause), 2);
        $display("queued soft: cause=%0d", rst_cause);

        // Feedback timeout, then sticky error through another soft reset.
        sync_rstn_fb = 1'b0;
        soft_pulse();
        run_cycles(70);
        check("timeout_err", int'(rst_err), 1);
        sync_rstn_fb = 1'b1;
        soft_pulse();
        run_cycles(40);
        check("err_sticky", int'(rst_err), 1);
        $display("feedback timeout: err=%0d busy=%0d", rst_err, rst_busy);

        // Async reset in the middle of WAIT_FB.
        sync_rstn_fb = 1'b0;
        soft_pulse();
        for (int i = 0; i < 100 && m_phase != PH_AWAIT; i++) step_cycle();
        run_cycles(3);
        async_hit(3);
        check("err_cleared", int'(rst_err), 0);
        sync_rstn_fb = 1'b1;
        run_cycles(40);
        $display("mid-sequence async reset: cause=%0d err=%0d", rst_cause, rst_err);

        // Random traffic.
        fb_low_left = 0;
        burst_left  = 0;
        for (int i = 0; i < 3000; i++) begin
            if (burst_left > 0) begin
                ext_rstn_raw = 1'b0;
                burst_left--;
            end else begin
                ext_rstn_raw = 1'b1;
                if ($urandom_range(59, 0) == 0) burst_left = $urandom_range(30, 1);
            end
            if (fb_low_left > 0) begin
                sync_rstn_fb = 1'b0;
                fb_low_left--;
            end else begin
                sync_rstn_fb = 1'b1;
                if ($urandom_range(149, 0) == 0) fb_low_left = $urandom_range(50, 10);
            end
            soft_rst_req = ($urandom_range(24, 0) == 0);
            if ($urandom_range(699, 0) == 0) begin
                soft_rst_req = 1'b0;
                async_hit(2);
            end
            step_cycle();
        end
        soft_rst_req = 1'b0;
        $display("random traffic: %0d cycles total", cyc);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/reset_req_gen.md
Name: reset_req_gen

Overview:
- Producer side of the global reset path. Generates the glitch-free, minimum-width, active-low reset request that drives the reset synchroniser's async_rstn_in.
- Request sources, in priority order: power-on, a debounced external reset pin, and a single-cycle soft-reset request from decoding-process control.
- Observes the synchroniser's sync_rstn as feedback to confirm release, and reports completion, cause and timeout errors.

Parameters:
- PULSE_CYCLES, 16: minimum low width of gen_rstn in sys_clk cycles (≥2).
- DEBOUNCE_CYCLES, 8: consecutive low samples of the external pin needed to count as a request (≥2).
- COOLDOWN_CYCLES, 4: dead time after release before a new request is accepted (≥1).
- FB_TIMEOUT, 32: maximum cycles to wait for sync_rstn_fb to go high after release.
- CNT_W, 8: width of the shared counter; must satisfy 2^CNT_W > max(PULSE_CYCLES, DEBOUNCE_CYCLES, COOLDOWN_CYCLES, FB_TIMEOUT).

Ports:
- sys_clk, input, 1: system clock; sole clock.
- async_rstn_in, input, 1: asynchronous active-low reset of this block (power-on reset).
- ext_rstn_raw, input, 1: raw external reset pin, active-low, asynchronous to sys_clk.
- soft_rst_req, input, 1: single-cycle soft-reset request, synchronous to sys_clk.
- sync_rstn_fb, input, 1: sync_rstn returned from the synchroniser.
- gen_rstn, output, 1: registered reset request; feeds the synchroniser's async_rstn_in.
- rst_busy, output, 1: high in any state other than IDLE.
- rst_done, output, 1: one-cycle pulse on confirmed release.
- rst_cause, output, 2: cause of the last sequence. 00 = POR, 01 = external, 10 = soft, 11 = reserved.
- rst_err, output, 1: sticky feedback-timeout flag; cleared only by async_rstn_in.

Behaviour:
- Reset is asynchronous and active-low on async_rstn_in; sys_clk is the only clock.
- While async_rstn_in = 0:
  - gen_rstn = 0, state = ASSERT, counter = 0, rst_cause = 00, rst_busy = 1, rst_done = 0, rst_err = 0.
  - Pending-soft flag = 0; debounce synchronisers preset to 1.
- After async_rstn_in rises, the POR pulse runs as a normal ASSERT.
- gen_rstn is driven directly from a flop, never from combinational decode.
- External pin input path:
  - 2-FF synchroniser, then a debounce counter.
  - ext_req asserts after DEBOUNCE_CYCLES consecutive synchronised lows.
  - ext_req deasserts on the first synchronised high.
  - A low shorter than DEBOUNCE_CYCLES is ignored.
- IDLE (gen_rstn = 1):
  - If ext_req: go to ASSERT, rst_cause = 01.
  - Else if soft_rst_req or pending-soft: go to ASSERT, rst_cause = 10, clear pending-soft.
  - If both occur in the same cycle, external wins and the soft request is dropped.
  - gen_rstn falls on the clock edge after the request cycle (latency 1).
- ASSERT (gen_rstn = 0):
  - Counter counts PULSE_CYCLES cycles, giving gen_rstn exactly PULSE_CYCLES cycles low.
  - At terminal count, if ext_req is still high, hold ASSERT (extend) until ext_req drops.
  - Otherwise go to WAIT_FB with gen_rstn = 1 and counter cleared.
  - soft_rst_req in this state is absorbed, not queued.
- WAIT_FB (gen_rstn = 1):
  - sync_rstn_fb = 1 → rst_done pulse, go to COOLDOWN.
  - FB_TIMEOUT cycles without feedback → rst_err = 1, no rst_done, go to COOLDOWN.
  - ext_req in this state → back to ASSERT, rst_cause = 01 (external preempts).
- COOLDOWN (gen_rstn = 1):
  - Lasts COOLDOWN_CYCLES, then IDLE.
  - soft_rst_req in this state sets pending-soft.
  - ext_req here is serviced from IDLE, since it is a level.
- Counter arithmetic:
  - Single unsigned CNT_W counter, cleared on every state entry.
  - Saturates; never wraps.
- async_rstn_in assertion mid-sequence forces the reset values above immediately.

Decomposition:
- Shared package holds:
  - State encoding: IDLE, ASSERT, WAIT_FB, COOLDOWN (2-bit).
  - rst_cause codes: CAUSE_POR, CAUSE_EXT, CAUSE_SOFT.
- One sub-module, rst_pin_debounce: 2-FF synchroniser plus debounce counter. Parameter DEBOUNCE_CYCLES; output ext_req.
- FSM and counter stay in reset_req_gen.

Test Plan:
- POR:
  - Stimulus: release async_rstn_in, tie sync_rstn_fb high.
  - Required: gen_rstn low for exactly 16 cycles after release, then high; rst_done pulses 1 cycle later; rst_cause = 00.
- Soft request:
  - Stimulus: in IDLE, pulse soft_rst_req at cycle 100.
  - Required: gen_rstn = 0 for cycles 101–116; rst_cause = 10; rst_busy high from 101 until the end of COOLDOWN.
- External glitch rejection and extension:
  - Stimulus: drive ext_rstn_raw low for 5 cycles. → Required: no reset.
  - Stimulus: drive ext_rstn_raw low for 40 cycles. → Required: gen_rstn low until 1 cycle after ext_req drops (extended beyond 16); rst_cause = 01.
- Simultaneous and queued requests:
  - Stimulus: ext_req and soft_rst_req in the same IDLE cycle. → Required: rst_cause = 01, no second sequence.
  - Stimulus: soft_rst_req during COOLDOWN. → Required: a second sequence starts on IDLE entry with rst_cause = 10.
- Feedback timeout:
  - Stimulus: hold sync_rstn_fb low.
  - Required: 32 cycles after release, rst_err = 1, no rst_done, return to IDLE. rst_err stays 1 through a subsequent soft reset and clears only on async_rstn_in.
- Mid-sequence async reset:
  - Stimulus: assert async_rstn_in during WAIT_FB.
  - Required: gen_rstn = 0 and rst_cause = 00 immediately; a full POR pulse follows release.
